// File: rtl/eth_rx_addr_filter.sv
// Receive-side destination-MAC filter for an 8-bit AXI-Stream path: buffers the header, decides, then replays or drops.
// Optional statistics counters are built only when ETH_RX_FILTER_STATS_EN is defined.
module eth_rx_addr_filter #(
    parameter int NumMacs  = 4,
    parameter int CntWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               s_tdata_i,
    input  logic                     s_tvalid_i,
    input  logic                     s_tlast_i,
    input  logic                     s_tuser_i,
    output logic                     s_tready_o,
    output logic [7:0]               m_tdata_o,
    output logic                     m_tvalid_o,
    output logic                     m_tlast_o,
    output logic                     m_tuser_o,
    input  logic                     m_tready_i,
    input  logic [NumMacs-1:0][47:0] mac_addr_i,
    input  logic [NumMacs-1:0]       mac_valid_i,
    input  logic                     promisc_i,
    input  logic                     bcast_en_i,
    input  logic                     mcast_en_i,
    input  logic                     cnt_clear_i,
    output logic [CntWidth-1:0]      cnt_accept_o,
    output logic [CntWidth-1:0]      cnt_drop_o,
    output logic [CntWidth-1:0]      cnt_runt_o
);

    typedef enum logic [1:0] {HDR, REPLAY, PASS, DROP} state_t;

    state_t      state, state_next;
    logic [7:0]  hdr [6];
    logic [2:0]  idx, ridx;
    logic [47:0] dest;
    logic        accept;
    logic        dec_ev, acc_ev, drop_ev, runt_ev;

    // The last header byte is matched straight from the bus, so the decision costs no extra cycle.
    always_comb begin
        dest   = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], s_tdata_i};
        accept = promisc_i | (bcast_en_i & (&dest)) | (mcast_en_i & dest[40]);
        for (int k = 0; k < NumMacs; k++) begin
            if (mac_valid_i[k] && dest == mac_addr_i[k]) accept = 1'b1;
        end
    end

    assign runt_ev = (state == HDR) && s_tvalid_i && s_tlast_i;
    assign dec_ev  = (state == HDR) && s_tvalid_i && !s_tlast_i && (idx == 3'd5);
    assign acc_ev  = dec_ev && accept;
    assign drop_ev = dec_ev && !accept;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        s_tready_o = 1'b1;
        m_tvalid_o = 1'b0;
        m_tdata_o  = 8'h00;
        m_tlast_o  = 1'b0;
        m_tuser_o  = 1'b0;
        case (state)
            HDR: begin
                if (dec_ev) state_next = accept ? REPLAY : DROP;
            end
            REPLAY: begin
                s_tready_o = 1'b0;
                m_tvalid_o = 1'b1;
                m_tdata_o  = hdr[ridx];
                if (m_tready_i && ridx == 3'd5) state_next = PASS;
            end
            PASS: begin
                s_tready_o = m_tready_i;
                m_tvalid_o = s_tvalid_i;
                m_tdata_o  = s_tdata_i;
                m_tlast_o  = s_tlast_i;
                m_tuser_o  = s_tuser_i;
                if (s_tvalid_i && m_tready_i && s_tlast_i) state_next = HDR;
            end
            DROP: begin
                if (s_tvalid_i && s_tlast_i) state_next = HDR;
            end
            default: state_next = HDR;
        endcase
    end

    // NOTE: state and indices use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= HDR;
            idx   <= 3'd0;
            ridx  <= 3'd0;
        end else begin
            state <= state_next;
            if (state == HDR && s_tvalid_i)
                idx <= (s_tlast_i || idx == 3'd5) ? 3'd0 : idx + 3'd1;
            if (state == REPLAY && m_tready_i)
                ridx <= (ridx == 3'd5) ? 3'd0 : ridx + 3'd1;
        end
    end

    // NOTE: the header buffer is not reset; it is always written before it is replayed.
    always_ff @(posedge clk_i) begin
        if (state == HDR && s_tvalid_i) hdr[idx] <= s_tdata_i;
    end

`ifdef ETH_RX_FILTER_STATS_EN
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clear_i) begin
            cnt_accept_o <= '0;
            cnt_drop_o   <= '0;
            cnt_runt_o   <= '0;
        end else begin
            if (acc_ev  && cnt_accept_o != '1) cnt_accept_o <= cnt_accept_o + CntOne;
            if (drop_ev && cnt_drop_o   != '1) cnt_drop_o   <= cnt_drop_o + CntOne;
            if (runt_ev && cnt_runt_o   != '1) cnt_runt_o   <= cnt_runt_o + CntOne;
        end
    end
`else
    logic stats_unused;
    assign stats_unused = ^{cnt_clear_i, acc_ev, drop_ev, runt_ev};
    assign cnt_accept_o = '0;
    assign cnt_drop_o   = '0;
    assign cnt_runt_o   = '0;
`endif

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Randomized bench for eth_rx_addr_filter: a frame-level model predicts forwarded bytes and counter values.
module tb_eth_rx_addr_filter;

`ifdef ETH_RX_FILTER_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif
    localparam int CntMax = 15;

    typedef enum int {EV_NONE, EV_ACC, EV_DROP, EV_RUNT} ev_t;
    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       user;
        ev_t        ev;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      s_tdata = 8'h00;
    logic            s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic            s_tready;
    logic [7:0]      m_tdata;
    logic            m_tvalid, m_tlast, m_tuser;
    logic            m_tready = 1'b1;
    logic [3:0][47:0] mac_addr = '0;
    logic [3:0]      mac_valid = '0;
    logic            promisc = 1'b0, bcast_en = 1'b0, mcast_en = 1'b0, cnt_clear = 1'b0;
    logic [3:0]      cnt_accept, cnt_drop, cnt_runt;

    eth_rx_addr_filter #(.NumMacs(4), .CntWidth(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tuser_i(s_tuser),
        .s_tready_o(s_tready),
        .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .m_tuser_o(m_tuser),
        .m_tready_i(m_tready),
        .mac_addr_i(mac_addr), .mac_valid_i(mac_valid),
        .promisc_i(promisc), .bcast_en_i(bcast_en), .mcast_en_i(mcast_en),
        .cnt_clear_i(cnt_clear),
        .cnt_accept_o(cnt_accept), .cnt_drop_o(cnt_drop), .cnt_runt_o(cnt_runt)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int    n_vec = 0, n_err = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t cur;
    bit    s_hs_prev = 1'b0;
    int    ready_pct = 100, valid_pct = 100;
    int    m_acc = 0, m_drp = 0, m_runt = 0;
    bit    clear_arm = 1'b0, sready_watch = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bump(input int c);
        if (!StatsEn) return 0;
        return (c < CntMax) ? c + 1 : CntMax;
    endfunction

    function automatic bit model_accept(input logic [47:0] dest);
        bit hit = promisc || (bcast_en && dest == 48'hffff_ffff_ffff) || (mcast_en && dest[40]);
        for (int k = 0; k < 4; k++)
            if (mac_valid[k] && mac_addr[k] == dest) hit = 1'b1;
        return hit;
    endfunction

    // Queue one frame; header bytes carry random tuser which must not appear on replay.
    task automatic send_frame(input logic [47:0] dest, input int len, input bit user);
        bit acc = model_accept(dest);
        for (int i = 0; i < len; i++) begin
            beat_t b, e;
            b.d    = (i < 6) ? dest[47 - 8*i -: 8] : 8'($urandom);
            b.last = (i == len - 1);
            b.user = b.last ? user : ((i < 6) ? 1'($urandom) : 1'b0);
            b.ev   = EV_NONE;
            if (len <= 6 && b.last) b.ev = EV_RUNT;
            else if (len > 6 && i == 5) b.ev = acc ? EV_ACC : EV_DROP;
            in_q.push_back(b);
            if (len > 6 && acc) begin
                e = b;
                if (i < 6) e.user = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        if (!s_tvalid || s_hs_prev) begin
            if (in_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
                cur = in_q.pop_front();
                s_tvalid = 1'b1; s_tdata = cur.d; s_tlast = cur.last; s_tuser = cur.user;
            end else begin
                s_tvalid = 1'b0;
            end
        end
        m_tready = ($urandom_range(0, 99) < ready_pct);
        @(negedge clk);
        check("cnt_accept", cnt_accept, m_acc);
        check("cnt_drop", cnt_drop, m_drp);
        check("cnt_runt", cnt_runt, m_runt);
        if (m_tvalid) begin
            if (exp_q.size() == 0) begin
                check("spurious_m_tvalid", m_tvalid, 1'b0);
            end else begin
                check("m_tdata", m_tdata, exp_q[0].d);
                check("m_tlast", m_tlast, exp_q[0].last);
                check("m_tuser", m_tuser, exp_q[0].user);
                if (m_tready) void'(exp_q.pop_front());
            end
        end
        if (sready_watch && s_tvalid) check("s_tready_high", s_tready, 1'b1);
        s_hs_prev = s_tvalid && s_tready;
        if (s_hs_prev && cur.ev != EV_NONE) begin
            if (clear_arm && cur.ev != EV_RUNT) begin
                cnt_clear = 1'b1;
                clear_arm = 1'b0;
                m_acc = 0; m_drp = 0; m_runt = 0;
            end else begin
                case (cur.ev)
                    EV_ACC:  m_acc  = bump(m_acc);
                    EV_DROP: m_drp  = bump(m_drp);
                    EV_RUNT: m_runt = bump(m_runt);
                    default: ;
                endcase
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((in_q.size() > 0 || (s_tvalid && !s_hs_prev) || exp_q.size() > 0) && n < 8000) begin
            step();
            n++;
        end
        if (n >= 8000) begin
            check("drain_timeout", exp_q.size(), 0);
            in_q.delete();
            exp_q.delete();
        end
        repeat (3) step();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_s_tready", s_tready, 1'b1);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tdata", m_tdata, 8'h00);
        check("rst_m_tlast", m_tlast, 1'b0);
        check("rst_m_tuser", m_tuser, 1'b0);
        check("rst_cnt_accept", cnt_accept, 0);
        check("rst_cnt_drop", cnt_drop, 0);
        check("rst_cnt_runt", cnt_runt, 0);

        // Unicast hit and miss against entry 2 only.
        for (int k = 0; k < 4; k++) mac_addr[k] = {16'($urandom), 32'($urandom)};
        mac_addr[2] = 48'h02_00_00_00_00_2a;
        mac_valid   = 4'b0100;
        send_frame(48'h02_00_00_00_00_2a, 64, 1'b0);
        drain();
        check("hit_cnt_accept", cnt_accept, StatsEn ? 1 : 0);
        sready_watch = 1'b1;
        send_frame(48'h02_00_00_00_00_2b, 64, 1'b0);
        drain();
        sready_watch = 1'b0;
        check("miss_cnt_drop", cnt_drop, StatsEn ? 1 : 0);

        // Broadcast through the multicast term, then multicast with the term disabled.
        bcast_en = 1'b0; mcast_en = 1'b1;
        send_frame(48'hffff_ffff_ffff, 20, 1'b0);
        drain();
        mcast_en = 1'b0;
        send_frame(48'h01_00_5e_00_00_01, 20, 1'b0);
        drain();

        // Runts under promiscuous mode, then a full frame.
        promisc = 1'b1;
        send_frame(48'h12_34_56_78_9a_bc, 5, 1'b0);
        send_frame(48'h12_34_56_78_9a_bc, 6, 1'b0);
        send_frame(48'h12_34_56_78_9a_bc, 60, 1'b0);
        drain();
        check("runt_cnt", cnt_runt, StatsEn ? 2 : 0);
        promisc = 1'b0;

        // Backpressure with an error flag on each last byte.
        ready_pct = 30; valid_pct = 70;
        for (int f = 0; f < 5; f++) send_frame(48'h02_00_00_00_00_2a, $urandom_range(7, 50), 1'b1);
        drain();
        ready_pct = 100; valid_pct = 100;

        // Saturation, then a clear landing on a decision cycle.
        promisc = 1'b1;
        for (int f = 0; f < 20; f++) send_frame({16'($urandom), 32'($urandom)}, 8, 1'b0);
        drain();
        check("sat_cnt_accept", cnt_accept, StatsEn ? CntMax : 0);
        clear_arm = 1'b1;
        send_frame(48'h02_00_00_00_00_2a, 10, 1'b0);
        drain();
        check("clear_cnt_accept", cnt_accept, 0);
        promisc = 1'b0;

        // Random configurations, batches of back-to-back frames.
        for (int b = 0; b < 30; b++) begin
            for (int k = 0; k < 4; k++) mac_addr[k] = {16'($urandom), 32'($urandom)};
            mac_valid = 4'($urandom);
            promisc   = ($urandom_range(0, 7) == 0);
            bcast_en  = 1'($urandom);
            mcast_en  = 1'($urandom);
            ready_pct = $urandom_range(30, 100);
            valid_pct = $urandom_range(50, 100);
            for (int f = 0; f < 3; f++) begin
                logic [47:0] d;
                case ($urandom_range(0, 3))
                    0:       d = mac_addr[$urandom_range(0, 3)];
                    1:       d = 48'hffff_ffff_ffff;
                    2:       d = {16'($urandom), 32'($urandom)} | 48'h01_00_00_00_00_00;
                    default: d = {16'($urandom), 32'($urandom)} & ~48'h01_00_00_00_00_00;
                endcase
                send_frame(d, $urandom_range(1, 40), 1'($urandom));
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
